hub_port_ctrl: RTL
==================

Name: hub_port_ctrl

Overview:
- Per-port repeater controller placed between each PHY MII receive interface and the shared hub repeater core.
- Decides whether a port's receive traffic may enter the shared repeater datapath, using two mechanisms:
  - Partition: isolates a port after excessive consecutive collisions or one over-long collision, and reconnects it after a clean frame.
  - Jabber: cuts a port whose carrier stays asserted too long.
- Instantiated once per hub port; its gated MII outputs feed the core's rx_dv/rx_er/rxd slice for that port.

Parameters:
- CC_LIMIT, 32: consecutive collided events that cause partition (1..63).
- LONG_COL_CYCLES, 512: consecutive collision cycles that cause immediate partition.
- RECONNECT_CYCLES, 128: minimum collision-free event length, in nibbles (512 bits), that resets the collision count and reconnects.
- JABBER_CYCLES, 12500: continuous rx_dv_in cycles before jabber (50000 bits).
- UNJAB_CYCLES, 24: consecutive idle cycles needed to leave jabber.

Ports:
- clk  in  1  MII nibble clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_dv_in  in  1  PHY receive data valid.
- rx_er_in  in  1  PHY receive error.
- rxd_in  in  4  PHY receive nibble.
- tx_en  in  1  core's registered tx_en for this port.
- rx_dv  out  1  gated data valid to the hub core.
- rx_er  out  1  gated receive error to the hub core.
- rxd  out  4  gated nibble to the hub core; 0 when gated.
- partitioned  out  1  port is partitioned.
- jabber  out  1  port is in jabber.

Behaviour:
- Reset: while rst_n is low, asynchronously force:
  - rx_dv, rx_er, rxd, partitioned, jabber to 0.
  - Collision count cc to 0.
  - All timers to 0.
  - Partition FSM to CONNECTED.
  - Forwarding latch to 0.
- Clocking: all state updates on posedge clk; all outputs are registered.
- Collision definition: col = rx_dv_in && tx_en in the same cycle.
- Event: a maximal run of cycles with rx_dv_in = 1. The event starts on a 0→1 transition and ends on the first cycle with rx_dv_in = 0.
- Per-event tracking:
  - len: saturating count of event length.
  - collided: set on any col cycle within the event.
  - colrun: consecutive col cycles; cleared on any non-col cycle.
- Forwarding latch fwd:
  - On the event start cycle, fwd = (state == CONNECTED) && !jabber.
  - fwd clears on the event end cycle, and on any cycle where jabber asserts.
  - A port that reconnects or unjabs mid-event stays silent until the next event. Truncated frames are never started.
- Datapath: one-cycle latency.
  - rx_dv <= rx_dv_in && fwd_next.
  - rx_er <= rx_er_in && fwd_next.
  - rxd <= fwd_next ? rxd_in : 0.
  - fwd_next is the latch value after this cycle's update.
- Partition FSM, state CONNECTED:
  - At event end: if collided, cc <= min(cc+1, 63); else if len >= RECONNECT_CYCLES, cc <= 0; shorter clean events leave cc unchanged.
  - Go to PARTITIONED when the updated cc >= CC_LIMIT.
  - Go to PARTITIONED the cycle colrun reaches LONG_COL_CYCLES, even mid-event. fwd clears that same cycle.
  - partitioned output follows the state, registered.
- Partition FSM, state PARTITIONED:
  - Monitoring continues; rx_dv is held 0.
  - An event ending with !collided && len >= RECONNECT_CYCLES: cc <= 0, go to CONNECTED.
  - Any other event leaves cc and state unchanged.
- Jabber:
  - jtimer counts consecutive rx_dv_in = 1 cycles and saturates.
  - jabber sets when jtimer reaches JABBER_CYCLES.
  - While jabber is set, a second timer counts consecutive rx_dv_in = 0 cycles; any 1 resets it.
  - jabber clears when that timer reaches UNJAB_CYCLES.
  - Jabber does not change cc or the partition state. The jabbering event is otherwise scored normally.
- Simultaneous events:
  - Jabber and partition both asserting in the same cycle: both flags set.
  - Event end and long-collision partition in the same cycle: partition wins; the cc increment still applies.
- Width rule: each timer is $clog2(limit+1) bits wide and saturates at its limit. There is no wrap-around.
- Reset asserted mid-frame: outputs drop immediately, without waiting for a clock edge.

Decomposition:
- Shared header (hub include file):
  - Default limits: CC_LIMIT, LONG_COL_CYCLES, RECONNECT_CYCLES, JABBER_CYCLES, UNJAB_CYCLES.
  - Partition state encodings: CONNECTED = 0, PARTITIONED = 1.
- One sub-module, hub_jabber:
  - Inputs: clk, rst_n, rx_dv_in.
  - Output: jabber.
  - Contains both jabber timers.

Test Plan:
- Clean 200-nibble frame with tx_en = 0 → rx_dv high for exactly 200 cycles, starting one cycle after rx_dv_in; rxd matches rxd_in delayed by one cycle; cc = 0; partitioned = 0.
- 32 back-to-back 40-nibble events, each with tx_en overlapping for 10 cycles → partitioned rises after the 32nd event ends; a 33rd frame produces rx_dv = 0 throughout.
- While partitioned: a 100-nibble clean frame → still partitioned. Then a 128-nibble clean frame → partitioned = 0 after it ends, and the next frame is forwarded.
- One event with col held for 512 cycles → partitioned and rx_dv fall on the cycle after col reaches 512. cc unchanged until the event ends, then incremented.
- rx_dv_in held for 13000 cycles → jabber = 1 and rx_dv = 0 from cycle 12500. After release, 23 idle cycles plus 1 active → jabber still 1; then 24 idle cycles → jabber = 0.
- rst_n pulsed low mid-frame in both a partitioned and a jabber condition → all outputs 0 immediately. After release, the next clean frame is forwarded.

Source files
------------

// File: rtl/hub_port_ctrl_pkg.sv
// Shared hub definitions: default port-control limits and partition state encoding.
package hub_port_ctrl_pkg;
   localparam int HUB_CC_LIMIT         = 32;     // consecutive collided events before partition
   localparam int HUB_LONG_COL_CYCLES  = 512;    // collision run that partitions immediately
   localparam int HUB_RECONNECT_CYCLES = 128;    // clean event length (nibbles) that reconnects
   localparam int HUB_JABBER_CYCLES    = 12500;  // continuous carrier before jabber
   localparam int HUB_UNJAB_CYCLES     = 24;     // idle run that releases jabber
   localparam int HUB_CC_W             = 6;      // collision count saturates at 63

   typedef enum logic {
      CONNECTED   = 1'b0,
      PARTITIONED = 1'b1
   } part_state_e;
endpackage

// File: rtl/hub_jabber.sv
// Jabber detector: cuts a port whose carrier stays up too long, releases after a quiet run.
module hub_jabber
   import hub_port_ctrl_pkg::*;
#(
   parameter int JABBER_CYCLES = HUB_JABBER_CYCLES,
   parameter int UNJAB_CYCLES  = HUB_UNJAB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_dv_in,
   output logic jabber,
   output logic jabber_nxt   // flag value after this cycle, lets the datapath cut the same cycle
);
   localparam int JW = $clog2(JABBER_CYCLES + 1);
   localparam int UW = $clog2(UNJAB_CYCLES + 1);
   localparam logic [JW-1:0] JMAX = JW'(JABBER_CYCLES);
   localparam logic [UW-1:0] UMAX = UW'(UNJAB_CYCLES);

   logic [JW-1:0] jtimer, jtimer_d;
   logic [UW-1:0] utimer, utimer_d;

   // Saturating carrier / idle timers and the set/clear decision
   always_comb begin
      jtimer_d = '0;
      if (rx_dv_in) jtimer_d = (jtimer == JMAX) ? JMAX : jtimer + JW'(1);
      utimer_d = '0;
      if (jabber && !rx_dv_in) utimer_d = (utimer == UMAX) ? UMAX : utimer + UW'(1);
      jabber_nxt = jabber;
      if (jabber) begin
         if (utimer_d == UMAX) jabber_nxt = 1'b0;
      end else if (jtimer_d == JMAX) begin
         jabber_nxt = 1'b1;
      end
      if (!jabber_nxt) utimer_d = '0;
   end

   // Timer and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jtimer <= '0;
         utimer <= '0;
         jabber <= 1'b0;
      end else begin
         jtimer <= jtimer_d;
         utimer <= utimer_d;
         jabber <= jabber_nxt;
      end
   end
endmodule

// File: rtl/hub_port_ctrl.sv
// Per-port repeater controller: partition and jabber gating of one PHY's MII receive stream.
module hub_port_ctrl
   import hub_port_ctrl_pkg::*;
#(
   parameter int CC_LIMIT         = HUB_CC_LIMIT,
   parameter int LONG_COL_CYCLES  = HUB_LONG_COL_CYCLES,
   parameter int RECONNECT_CYCLES = HUB_RECONNECT_CYCLES,
   parameter int JABBER_CYCLES    = HUB_JABBER_CYCLES,
   parameter int UNJAB_CYCLES     = HUB_UNJAB_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_dv_in,
   input  logic       rx_er_in,
   input  logic [3:0] rxd_in,
   input  logic       tx_en,
   output logic       rx_dv,
   output logic       rx_er,
   output logic [3:0] rxd,
   output logic       partitioned,
   output logic       jabber
);
   localparam int LW = $clog2(RECONNECT_CYCLES + 1);
   localparam int CW = $clog2(LONG_COL_CYCLES + 1);
   localparam logic [LW-1:0]       LMAX  = LW'(RECONNECT_CYCLES);
   localparam logic [CW-1:0]       CMAX  = CW'(LONG_COL_CYCLES);
   localparam logic [HUB_CC_W-1:0] CCMAX = '1;
   localparam logic [HUB_CC_W-1:0] CCLIM = HUB_CC_W'(CC_LIMIT);

   part_state_e         state, state_d;
   logic [HUB_CC_W-1:0] cc, cc_d;
   logic [LW-1:0]       len, len_d;
   logic [CW-1:0]       colrun, colrun_d;
   logic                collided, collided_d;
   logic                lc_part, lc_part_d;   // this event already partitioned on a long collision
   logic                prev_dv, fwd, fwd_d, jabber_nxt;
   logic                col, ev_start, ev_end, lc_hit;

   assign col         = rx_dv_in && tx_en;
   assign ev_start    = rx_dv_in && !prev_dv;
   assign ev_end      = !rx_dv_in && prev_dv;
   assign lc_hit      = (state == CONNECTED) && (colrun_d == CMAX);
   assign partitioned = (state == PARTITIONED);

   hub_jabber #(
      .JABBER_CYCLES (JABBER_CYCLES),
      .UNJAB_CYCLES  (UNJAB_CYCLES)
   ) u_jabber (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_dv_in   (rx_dv_in),
      .jabber     (jabber),
      .jabber_nxt (jabber_nxt)
   );

   // Per-event length, collided flag and collision run
   always_comb begin
      len_d      = len;
      collided_d = collided;
      colrun_d   = '0;
      if (rx_dv_in) begin
         if (ev_start) begin
            len_d      = LW'(1);
            collided_d = col;
         end else begin
            len_d      = (len == LMAX) ? LMAX : len + LW'(1);
            collided_d = collided || col;
         end
         if (col) colrun_d = (colrun == CMAX) ? CMAX : colrun + CW'(1);
      end
   end

   // Partition next state and collision count; an event cut by a long collision is
   // still scored as a connected-port event when it ends
   always_comb begin
      state_d   = state;
      cc_d      = cc;
      lc_part_d = ev_start ? 1'b0 : lc_part;
      if (lc_hit) begin
         state_d   = PARTITIONED;
         lc_part_d = 1'b1;
      end
      if (ev_end) begin
         if (state == CONNECTED || lc_part) begin
            if (collided)          cc_d = (cc == CCMAX) ? CCMAX : cc + HUB_CC_W'(1);
            else if (len >= LMAX)  cc_d = '0;
            if (cc_d >= CCLIM) state_d = PARTITIONED;
         end else if (!collided && len >= LMAX) begin
            cc_d    = '0;
            state_d = CONNECTED;
         end
         lc_part_d = 1'b0;
      end
   end

   // Forwarding latch: decided at event start, dropped at end, on long collision or jabber
   always_comb begin
      fwd_d = fwd;
      if (ev_start)    fwd_d = (state == CONNECTED) && !jabber;
      else if (ev_end) fwd_d = 1'b0;
      if (lc_hit || jabber_nxt) fwd_d = 1'b0;
   end

   // State register; prev_dv resets high so a frame already in flight at reset
   // release is not mistaken for a fresh start and forwarded truncated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CONNECTED;
         cc       <= '0;
         len      <= '0;
         colrun   <= '0;
         collided <= 1'b0;
         lc_part  <= 1'b0;
         prev_dv  <= 1'b1;
         fwd      <= 1'b0;
      end else begin
         state    <= state_d;
         cc       <= cc_d;
         len      <= len_d;
         colrun   <= colrun_d;
         collided <= collided_d;
         lc_part  <= lc_part_d;
         prev_dv  <= rx_dv_in;
         fwd      <= fwd_d;
      end
   end

   // Gated MII towards the repeater core, one cycle of latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_dv <= 1'b0;
         rx_er <= 1'b0;
         rxd   <= '0;
      end else begin
         rx_dv <= rx_dv_in && fwd_d;
         rx_er <= rx_er_in && fwd_d;
         rxd   <= fwd_d ? rxd_in : 4'h0;
      end
   end
endmodule
